// File: rtl/keccak_multi_dispatch.sv
// keccak_multi_dispatch: register-bus job dispatcher for NUM_CH Keccak channels.
// Jobs pushed through the JOB register are queued and handed round-robin to idle
// channels; per-channel done pulses are counted and merged into one interrupt.
// Optional watchdog per channel is compiled in with `define KECCAK_DISPATCH_TIMEOUT_EN.
// The register request/response structs are flattened into plain logic ports.
module keccak_multi_dispatch #(
    parameter int NUM_CH      = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ID_W        = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_req_valid_i,
    input  logic                   reg_req_write_i,
    input  logic [31:0]            reg_req_addr_i,
    input  logic [31:0]            reg_req_wdata_i,
    input  logic [3:0]             reg_req_wstrb_i,
    output logic [31:0]            reg_rsp_rdata_o,
    output logic                   reg_rsp_error_o,
    output logic                   reg_rsp_ready_o,
    output logic [NUM_CH-1:0]      start_o,
    output logic [NUM_CH*ID_W-1:0] job_id_o,
    input  logic [NUM_CH-1:0]      done_i,
    output logic [NUM_CH-1:0]      busy_o,
    output logic                   intr_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [ID_W-1:0]        r_fifo [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   r_ovf, r_intr;
    logic [NUM_CH-1:0]      r_busy, r_start, r_irq_en, r_pend;
    logic [NUM_CH*ID_W-1:0] r_job_id;
    logic [PW-1:0]          r_rr;
    logic [31:0]            r_done_cnt;

    logic                   w_full, w_empty, w_push, w_pop, w_found;
    logic                   w_ovf_set, w_ovf_clr, w_en_we, w_cnt_clr;
    logic [NUM_CH-1:0]      w_pend_w1c, w_tmo_w1c, w_disp, w_done_acc, w_tmo_hit, w_tmo_rd;
    logic [PW-1:0]          w_pick;
    logic [31:0]            w_rdata, w_status, w_done_inc;
    logic                   w_error;
    int                     w_idx;
    logic                   w_unused_bits;

    // Byte strobes are ignored (full-word accesses) and wide wdata bits are don't-care.
    assign w_unused_bits = (^{reg_req_wstrb_i, reg_req_wdata_i}) ^ (TIMEOUT_CYC > 0);

    assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_done_acc = done_i & r_busy;

    // Status word assembly
    always_comb begin
        w_status            = '0;
        w_status[0]         = w_full;
        w_status[1]         = w_empty;
        w_status[2]         = r_ovf;
        w_status[8 +: 7]    = 7'(r_count);
        w_status[16 +: NUM_CH] = r_busy;
    end

    // Register decode: combinational read data/error and write strobes
    always_comb begin
        w_rdata    = '0;
        w_error    = 1'b0;
        w_push     = 1'b0;
        w_ovf_set  = 1'b0;
        w_ovf_clr  = 1'b0;
        w_en_we    = 1'b0;
        w_cnt_clr  = 1'b0;
        w_pend_w1c = '0;
        w_tmo_w1c  = '0;
        if (reg_req_valid_i) begin
            case (reg_req_addr_i)
                32'h00: if (reg_req_write_i) begin
                    if (w_full) begin
                        w_error   = 1'b1;
                        w_ovf_set = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                32'h04: begin
                    w_rdata   = w_status;
                    w_ovf_clr = reg_req_write_i & reg_req_wdata_i[2];
                end
                32'h08: begin
                    w_rdata[NUM_CH-1:0] = r_irq_en;
                    w_en_we             = reg_req_write_i;
                end
                32'h0C: begin
                    w_rdata[NUM_CH-1:0] = r_pend;
                    if (reg_req_write_i) w_pend_w1c = reg_req_wdata_i[NUM_CH-1:0];
                end
                32'h10: begin
                    w_rdata   = r_done_cnt;
                    w_cnt_clr = reg_req_write_i;
                end
                32'h14: begin
                    w_rdata[NUM_CH-1:0] = w_tmo_rd;
                    if (reg_req_write_i) w_tmo_w1c = reg_req_wdata_i[NUM_CH-1:0];
                end
                default: w_error = 1'b1;
            endcase
        end
    end

    assign reg_rsp_rdata_o = w_rdata;
    assign reg_rsp_error_o = w_error;
    assign reg_rsp_ready_o = 1'b1;

    // Round-robin search for the first idle channel starting at rr pointer
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = (int'(r_rr) + i) % NUM_CH;
            if (!w_found && !r_busy[w_idx]) begin
                w_found = 1'b1;
                w_pick  = PW'(w_idx);
            end
        end
    end

    assign w_pop  = !w_empty && w_found;
    assign w_disp = w_pop ? (NUM_CH'(1) << w_pick) : '0;

    // Number of accepted completions this cycle
    always_comb begin
        w_done_inc = '0;
        for (int i = 0; i < NUM_CH; i++) w_done_inc = w_done_inc + 32'(w_done_acc[i]);
    end

`ifdef KECCAK_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0]     r_tcnt [NUM_CH];
    logic [NUM_CH-1:0] r_tmo;

    // A done in the same cycle wins over the watchdog
    always_comb begin
        w_tmo_hit = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_tmo_hit[i] = r_busy[i] && !done_i[i] && (r_tcnt[i] == TW'(TIMEOUT_CYC - 1));
    end
    assign w_tmo_rd = r_tmo;

    // Watchdog counters: restart on dispatch, advance while busy; sticky timeout flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CH; i++) r_tcnt[i] <= '0;
            r_tmo <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_disp[i])      r_tcnt[i] <= '0;
                else if (r_busy[i]) r_tcnt[i] <= r_tcnt[i] + 1'b1;
            end
            r_tmo <= (r_tmo & ~w_tmo_w1c) | w_tmo_hit;
        end
    end
`else
    assign w_tmo_hit = '0;
    assign w_tmo_rd  = '0;
`endif

    // FIFO storage: write-only array, head read by pointer
    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wr_ptr] <= reg_req_wdata_i[ID_W-1:0];
    end

    // FIFO pointers, occupancy and overflow flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
        end
    end

    // Dispatch, busy tracking, pending/interrupt and completion counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy     <= '0;
            r_start    <= '0;
            r_job_id   <= '0;
            r_rr       <= '0;
            r_irq_en   <= '0;
            r_pend     <= '0;
            r_done_cnt <= '0;
            r_intr     <= 1'b0;
        end else begin
            r_start <= w_disp;
            r_busy  <= (r_busy & ~w_done_acc & ~w_tmo_hit) | w_disp;
            for (int i = 0; i < NUM_CH; i++)
                if (w_disp[i]) r_job_id[i*ID_W +: ID_W] <= r_fifo[r_rd_ptr];
            if (w_pop) r_rr <= (w_pick == PW'(NUM_CH - 1)) ? '0 : w_pick + 1'b1;
            if (w_en_we) r_irq_en <= reg_req_wdata_i[NUM_CH-1:0];
            r_pend     <= (r_pend & ~w_pend_w1c) | w_done_acc | w_tmo_hit;
            r_done_cnt <= (w_cnt_clr ? 32'd0 : r_done_cnt) + w_done_inc;
            r_intr     <= |(r_pend & r_irq_en);
        end
    end

    assign start_o  = r_start;
    assign job_id_o = r_job_id;
    assign busy_o   = r_busy;
    assign intr_o   = r_intr;
endmodule

// File: doc/keccak_multi_dispatch.md
Name: keccak_multi_dispatch

Overview:
- Register-bus job dispatcher that sits between the X-HEEP external peripheral port and NUM_CH Keccak accelerator instances.
- Software pushes job IDs into an internal FIFO. The block hands each job to an idle channel in round-robin order.
- It tracks per-channel busy state, counts completions and merges per-channel done events into one maskable interrupt line on ext_intr_vector.

Parameters:
- NUM_CH, 2: number of accelerator channels, 1..16.
- FIFO_DEPTH, 4: job FIFO entries, power of two, 2..64.
- ID_W, 8: job ID width, 1..32.
- TIMEOUT_CYC, 1024: watchdog limit in cycles; used only with the optional feature.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset.
- reg_req_i, in, reg_req_t: register bus request (valid, write, addr, wdata, wstrb).
- reg_rsp_o, out, reg_rsp_t: register bus response (rdata, error, ready).
- start_o, out, NUM_CH: one-cycle start pulse per channel.
- job_id_o, out, NUM_CH*ID_W: job ID per channel; channel c occupies bits [c*ID_W +: ID_W].
- done_i, in, NUM_CH: one-cycle completion pulse per channel.
- busy_o, out, NUM_CH: channel busy flags.
- intr_o, out, 1: aggregated interrupt, level.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: all outputs 0. FIFO empty, rr_ptr=0, all registers 0.
- Bus timing: ready=1 always; zero-wait. rdata and error are combinational on a valid request. Writes take effect on the next clock edge.
- Register map (byte offsets, 32-bit words):
  - 0x00 JOB, W: push wdata[ID_W-1:0] into the FIFO. If the FIFO is full (registered count == FIFO_DEPTH): error=1, data dropped, STATUS.ovf set. Read returns 0.
  - 0x04 STATUS, R: [0] full; [1] empty; [2] ovf (sticky); [8+:7] fifo count; [16+:NUM_CH] busy mask. Writing 1 to bit 2 clears ovf; all other bits are read-only.
  - 0x08 IRQ_EN, RW: [NUM_CH-1:0].
  - 0x0C IRQ_PEND, R/W1C: [NUM_CH-1:0].
  - 0x10 DONE_CNT, R: 32-bit count of accepted completions, wraps 0xFFFFFFFF->0. Any write clears it to 0.
  - 0x14 TIMEOUT, R/W1C: [NUM_CH-1:0]; see Optional Feature.
  - Any other address: rdata=0, error=1, no side effect.
- Dispatch:
  - Each cycle where the FIFO is non-empty and the registered busy has at least one 0 bit: pick the first idle channel c, searching from rr_ptr upward modulo NUM_CH.
  - On that pick: start_o[c]=1 for exactly one cycle (registered); job_id_o[c] is loaded with the FIFO head and held until the next dispatch to c; busy_o[c]=1 from the same edge; FIFO pops; rr_ptr <= (c+1) mod NUM_CH.
  - At most one dispatch per cycle.
- Latency: JOB write at edge N into an empty FIFO with an idle channel -> start_o high in cycle N+1.
- Completion: done_i[c] while busy_o[c]=1 does all of the following at the next edge: busy_o[c]<=0, IRQ_PEND[c]<=1, DONE_CNT+=1. done_i[c] while idle is ignored.
- Same-cycle events:
  - Push and pop in the same cycle: count unchanged. A push at registered full is still rejected even when a pop occurs in the same cycle.
  - done_i[c] and a dispatch decision in the same cycle: the decision uses registered busy, so c is not eligible until the following cycle.
  - W1C of IRQ_PEND[c] and a new done on c in the same cycle: set wins.
  - DONE_CNT clear and a completion in the same cycle: result is 1.
- Several done_i bits in the same cycle: DONE_CNT adds popcount(done_i & busy_o).
- Interrupt: intr_o = |(IRQ_PEND & IRQ_EN), registered (one-cycle delay from pending update).
- Reset mid-operation: all state is cleared immediately. Jobs in flight are forgotten; later done_i pulses are ignored because the channels are idle.

Optional Feature:
- Macro: KECCAK_DISPATCH_TIMEOUT_EN.
- Enabled:
  - Per-channel counter runs while busy and resets on dispatch.
  - When it reaches TIMEOUT_CYC-1 with no done: channel forced idle, TIMEOUT[c]<=1, IRQ_PEND[c]<=1. DONE_CNT is not incremented.
  - A done arriving on the same cycle as the timeout takes priority and is a normal completion.
- Disabled: no counters; TIMEOUT reads 0; writes to it are ignored with error=0.

Test Plan:
- Reset, then read all registers -> 0x04 reads 0x00000002 (empty); all others 0; intr_o=0; start_o=0.
- NUM_CH=2: write JOB 0x11, 0x22, 0x33 back-to-back -> start_o[0] with id 0x11 one cycle after the first write, start_o[1] with 0x22 next; 0x33 stays queued (count=1). done_i[0] -> 0x33 dispatched to ch0 (rr order), DONE_CNT=1.
- FIFO_DEPTH=4, both channels busy: push 5 jobs -> 5th write returns error=1; STATUS = full|ovf, count=4. W1C bit 2 -> ovf cleared.
- IRQ_EN=0b01; done on ch1 then ch0 -> IRQ_PEND=0b11; intr_o rises only after ch0's done. W1C 0b01 in the same cycle as a new ch0 done -> PEND[0] stays 1.
- done_i on idle channel -> no change to DONE_CNT or PEND. Access to 0x20 -> error=1, rdata=0.
- With KECCAK_DISPATCH_TIMEOUT_EN and TIMEOUT_CYC=16: dispatch, no done for 16 cycles -> busy_o cleared, TIMEOUT=0b01, DONE_CNT unchanged. Without the macro -> busy_o stays 1 and TIMEOUT reads 0.
